// File: rtl/sram_march_test_if.sv
// Request/response bus between the march-test engine (master) and the SRAM controller (slave).
interface sram_march_test_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 8
);
   logic              mem;
   logic              rw;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data2ram;
   logic [DATA_W-1:0] data2fpga;

   modport master (output mem, rw, addr, data2ram, input ready, data2fpga);
   modport slave  (input mem, rw, addr, data2ram, output ready, data2fpga);
endinterface

// File: rtl/sram_march_test.sv
// SRAM built-in self-test: write/read-back passes over an address window with selectable patterns,
// reporting pass/fail, saturating error count, first failing word and controller timeouts.
module sram_march_test #(
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned END_ADDR   = 255,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic [1:0]          i_mode,
   sram_march_test_if.master   bus,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_result,
   output logic                o_timeout,
   output logic [CNT_W-1:0]    o_err_count,
   output logic [ADDR_W-1:0]   o_fail_addr,
   output logic [DATA_W-1:0]   o_fail_data
);

   localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] L_START = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] L_END   = ADDR_W'(END_ADDR);

   typedef enum logic [2:0] {
      StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StCheck, StNextPat, StDone
   } state_e;

   state_e              r_state, w_state;
   logic [1:0]          r_mode, w_mode;
   logic [1:0]          r_pat, w_pat;
   logic [ADDR_W-1:0]   r_a, w_a;
   logic                r_fell, w_fell;
   logic [TCNT_W-1:0]   r_tcnt, w_tcnt;
   logic [DATA_W-1:0]   r_rdata, w_rdata;
   logic                r_mem, w_mem;
   logic                r_rw, w_rw;
   logic [ADDR_W-1:0]   r_addr, w_addr;
   logic [DATA_W-1:0]   r_data2ram, w_data2ram;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
   logic                r_result, w_result;
   logic                r_timeout, w_timeout;
   logic [CNT_W-1:0]    r_err, w_err;
   logic [ADDR_W-1:0]   r_fail_addr, w_fail_addr;
   logic [DATA_W-1:0]   r_fail_data, w_fail_data;
   logic                w_complete;
   logic                w_tmo;

   // pat: 0 = address, 1 = inverted address, 2 = checkerboard keyed on address parity
   function automatic logic [DATA_W-1:0] f_pat(input logic [1:0] pat, input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = DATA_W'(a);
      case (pat)
         2'd1:    v = ~v;
         2'd2:    for (int i = 0; i < DATA_W; i++) v[i] = (i % 2 == 0) ? ~a[0] : a[0];
         default: ;
      endcase
      return v;
   endfunction

   // A transaction completes only on ready high after it has been seen low since the request.
   assign w_complete = bus.ready && r_fell;
   assign w_tmo      = (r_tcnt == TCNT_W'(TIMEOUT - 1));

   always_comb begin
      w_state = r_state;      w_mode = r_mode;           w_pat = r_pat;
      w_a = r_a;              w_fell = r_fell | ~bus.ready;
      w_tcnt = r_tcnt + 1'b1; w_rdata = r_rdata;         w_mem = 1'b0;
      w_rw = r_rw;            w_addr = r_addr;           w_data2ram = r_data2ram;
      w_busy = r_busy;        w_done = r_done;           w_result = r_result;
      w_timeout = r_timeout;  w_err = r_err;             w_fail_addr = r_fail_addr;
      w_fail_data = r_fail_data;
      case (r_state)
         StIdle, StDone: begin
            if (i_en) begin
               w_mode      = i_mode;
               w_pat       = (i_mode == 2'b11) ? 2'd0 : i_mode;
               w_err       = '0;
               w_fail_addr = '0;
               w_fail_data = '0;
               w_timeout   = 1'b0;
               w_result    = 1'b0;
               w_done      = 1'b0;
               w_busy      = 1'b1;
               w_a         = L_START;
               w_state     = StWrReq;
            end
         end
         StWrReq, StRdReq: begin
            if (bus.ready) begin
               w_mem      = 1'b1;
               w_rw       = (r_state == StRdReq);
               w_addr     = r_a;
               w_data2ram = (r_state == StRdReq) ? r_data2ram : f_pat(r_pat, r_a);
               w_fell     = 1'b0;
               w_tcnt     = '0;
               w_state    = (r_state == StRdReq) ? StRdWait : StWrWait;
            end
         end
         StWrWait, StRdWait: begin
            if (w_complete) begin
               if (r_state == StRdWait) begin
                  w_rdata = bus.data2fpga;
                  w_state = StCheck;
               end else if (r_a == L_END) begin
                  w_a     = L_START;
                  w_state = StRdReq;
               end else begin
                  w_a     = r_a + 1'b1;
                  w_state = StWrReq;
               end
            end else if (w_tmo) begin
               w_timeout = 1'b1;
               w_result  = 1'b0;
               w_busy    = 1'b0;
               w_done    = 1'b1;
               w_state   = StDone;
            end
         end
         StCheck: begin
            if (r_rdata != f_pat(r_pat, r_a)) begin
               if (r_err != '1) w_err = r_err + 1'b1;
               if (r_err == '0) begin
                  w_fail_addr = r_a;
                  w_fail_data = r_rdata;
               end
            end
            if (r_a == L_END) begin
               w_state = StNextPat;
            end else begin
               w_a     = r_a + 1'b1;
               w_state = StRdReq;
            end
         end
         StNextPat: begin
            if (r_mode == 2'b11 && r_pat != 2'd2) begin
               w_pat   = r_pat + 1'b1;
               w_a     = L_START;
               w_state = StWrReq;
            end else begin
               w_busy   = 1'b0;
               w_done   = 1'b1;
               w_result = (r_err == '0) && !r_timeout;
               w_state  = StDone;
            end
         end
         default: w_state = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;  r_mode <= '0;       r_pat <= '0;
         r_a <= '0;          r_fell <= 1'b0;     r_tcnt <= '0;
         r_rdata <= '0;      r_mem <= 1'b0;      r_rw <= 1'b0;
         r_addr <= '0;       r_data2ram <= '0;   r_busy <= 1'b0;
         r_done <= 1'b0;     r_result <= 1'b0;   r_timeout <= 1'b0;
         r_err <= '0;        r_fail_addr <= '0;  r_fail_data <= '0;
      end else begin
         r_state <= w_state; r_mode <= w_mode;           r_pat <= w_pat;
         r_a <= w_a;         r_fell <= w_fell;           r_tcnt <= w_tcnt;
         r_rdata <= w_rdata; r_mem <= w_mem;             r_rw <= w_rw;
         r_addr <= w_addr;   r_data2ram <= w_data2ram;   r_busy <= w_busy;
         r_done <= w_done;   r_result <= w_result;       r_timeout <= w_timeout;
         r_err <= w_err;     r_fail_addr <= w_fail_addr; r_fail_data <= w_fail_data;
      end
   end

   assign bus.mem      = r_mem;
   assign bus.rw       = r_rw;
   assign bus.addr     = r_addr;
   assign bus.data2ram = r_data2ram;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_result     = r_result;
   assign o_timeout    = r_timeout;
   assign o_err_count  = r_err;
   assign o_fail_addr  = r_fail_addr;
   assign o_fail_data  = r_fail_data;

endmodule

// File: tb/tb_sram_march_test.sv
// Bench for sram_march_test: SRAM controller model plus scoreboard checked at each done rise.
module tb_sram_march_test;

   logic        clk;
   logic        rst;
   logic        i_en;
   logic [1:0]  i_mode;
   logic        o_busy, o_done, o_result, o_timeout;
   logic [15:0] o_err_count;
   logic [19:0] o_fail_addr;
   logic [7:0]  o_fail_data;

   sram_march_test_if #(.ADDR_W(20), .DATA_W(8)) bus ();

   sram_march_test #(
      .ADDR_W(20), .DATA_W(8), .START_ADDR(0), .END_ADDR(255), .CNT_W(16), .TIMEOUT(64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_en        (i_en),
      .i_mode      (i_mode),
      .bus         (bus),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result),
      .o_timeout   (o_timeout),
      .o_err_count (o_err_count),
      .o_fail_addr (o_fail_addr),
      .o_fail_data (o_fail_data)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Controller model: ready low for 3 cycles (60 ns) after each accepted request.
   logic [7:0] sram [256];
   logic [7:0] w5_log [$];
   int         dly;
   logic       stuck, corrupt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ready     <= 1'b1;
         bus.data2fpga <= 8'h00;
         dly           <= 0;
      end else if (bus.mem && !stuck) begin
         bus.ready <= 1'b0;
         dly       <= 3;
         if (bus.rw) begin
            bus.data2fpga <= (corrupt && (bus.addr == 20'h12 || bus.addr == 20'h80)) ?
                             8'h00 : sram[bus.addr[7:0]];
         end else begin
            sram[bus.addr[7:0]] <= bus.data2ram;
            if (bus.addr == 20'd5) w5_log.push_back(bus.data2ram);
         end
      end else if (dly > 0) begin
         dly <= dly - 1;
         if (dly == 1) bus.ready <= 1'b1;
      end
   end

   int   mem_total = 0;
   int   b2b = 0;
   logic mem_prev = 1'b0;

   always @(posedge clk) begin
      mem_prev <= bus.mem;
      if (bus.mem) mem_total <= mem_total + 1;
      if (bus.mem && mem_prev) b2b <= b2b + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        res;
      logic        tmo;
      logic [15:0] err;
      logic [19:0] faddr;
      logic [7:0]  fdata;
      int          mem_exp;
      int          base;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   logic done_prev = 1'b0;

   function automatic exp_t mk(input logic res, input logic tmo, input logic [15:0] err,
                               input logic [19:0] fa, input logic [7:0] fd, input int nm);
      exp_t e;
      e.res = res; e.tmo = tmo; e.err = err; e.faddr = fa; e.fdata = fd;
      e.mem_exp = nm; e.base = 0;
      return e;
   endfunction

   // Monitor: each done rise pops one expected run summary.
   always @(negedge clk) begin
      done_prev <= o_done;
      if (o_done && !done_prev) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: done rose with no expected run queued");
         end else begin
            mon_e = sb.pop_front();
            check("result",    o_result,    mon_e.res);
            check("timeout",   o_timeout,   mon_e.tmo);
            check("err_count", o_err_count, mon_e.err);
            check("fail_addr", o_fail_addr, mon_e.faddr);
            check("fail_data", o_fail_data, mon_e.fdata);
            check("mem_count", mem_total - mon_e.base, mon_e.mem_exp);
            check("busy_at_done", o_busy, 1'b0);
         end
      end
   end

   task automatic pulse_en(input logic [1:0] m);
      @(negedge clk);
      i_mode = m;
      i_en   = 1'b1;
      @(negedge clk);
      i_en   = 1'b0;
   endtask

   task automatic start_run(input logic [1:0] m, input exp_t e);
      e.base = mem_total;
      sb.push_back(e);
      pulse_en(m);
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      while (!o_done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, o_done, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctrl"}, {bus.mem, bus.rw, o_busy, o_done, o_result, o_timeout}, 0);
      check({tag, "_addr"}, bus.addr, 0);
      check({tag, "_data2ram"}, bus.data2ram, 0);
      check({tag, "_err"}, o_err_count, 0);
      check({tag, "_fail_addr"}, o_fail_addr, 0);
      check({tag, "_fail_data"}, o_fail_data, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      int   k;
      logic found;
      for (int i = 0; i < 256; i++) sram[i] = 8'h00;
      rst = 1'b0; i_en = 1'b0; i_mode = 2'b00; stuck = 1'b0; corrupt = 1'b0;
      #3 rst = 1'b1;
      #5 check_reset("reset");
      #5 rst = 1'b0;

      // mode 00: 256 writes then 256 reads
      start_run(2'b00, mk(1'b1, 1'b0, 16'd0, 20'd0, 8'h00, 512));
      wait_done("t1_done", 6000);

      // mode 11: addr, ~addr, checkerboard
      w5_log.delete();
      start_run(2'b11, mk(1'b1, 1'b0, 16'd0, 20'd0, 8'h00, 1536));
      wait_done("t2_done", 20000);
      check("t2_w5_count", w5_log.size(), 3);
      if (w5_log.size() == 3) begin
         check("t2_w5_addr_pat", w5_log[0], 8'h05);
         check("t2_w5_inv_pat",  w5_log[1], 8'hFA);
         check("t2_w5_chk_pat",  w5_log[2], 8'hAA);
      end
      check("t2_sram5_final", sram[5], 8'hAA);
      check("t2_sram80_final", sram[8'h80], 8'h55);

      // corrupted reads at 0x12 and 0x80
      corrupt = 1'b1;
      start_run(2'b00, mk(1'b0, 1'b0, 16'd2, 20'h12, 8'h00, 512));
      wait_done("t3_done", 6000);
      corrupt = 1'b0;

      // controller never drops ready
      stuck = 1'b1;
      start_run(2'b00, mk(1'b0, 1'b1, 16'd0, 20'd0, 8'h00, 1));
      wait_done("t4_done", 500);
      base = mem_total;
      repeat (100) @(negedge clk);
      check("t4_no_mem_after_timeout", mem_total - base, 0);
      check("t4_done_held", o_done, 1'b1);
      stuck = 1'b0;

      // reset during the read pass at 0x40
      pulse_en(2'b00);
      found = 1'b0;
      k = 0;
      while (!found && k < 6000) begin
         @(negedge clk);
         k++;
         if (bus.mem && bus.rw && bus.addr == 20'h40) found = 1'b1;
      end
      check("t5_found_rd40", found, 1'b1);
      #3 rst = 1'b1;
      #1 check_reset("t5_async");
      base = mem_total;
      repeat (3) @(negedge clk);
      check("t5_no_mem_in_reset", mem_total - base, 0);
      rst = 1'b0;
      start_run(2'b00, mk(1'b1, 1'b0, 16'd0, 20'd0, 8'h00, 512));
      found = 1'b0;
      k = 0;
      while (!found && k < 50) begin
         @(negedge clk);
         k++;
         if (bus.mem) found = 1'b1;
      end
      check("t5_restart_mem", found, 1'b1);
      check("t5_restart_addr", bus.addr, 0);
      check("t5_restart_rw", bus.rw, 1'b0);
      wait_done("t5_done", 6000);

      // en while busy is ignored; en while done restarts
      start_run(2'b00, mk(1'b1, 1'b0, 16'd0, 20'd0, 8'h00, 512));
      repeat (50) @(negedge clk);
      pulse_en(2'b01);
      check("t6_busy_after_en", o_busy, 1'b1);
      wait_done("t6_done_a", 6000);
      start_run(2'b10, mk(1'b1, 1'b0, 16'd0, 20'd0, 8'h00, 512));
      check("t6_done_cleared", o_done, 1'b0);
      check("t6_result_cleared", o_result, 1'b0);
      check("t6_busy_restart", o_busy, 1'b1);
      wait_done("t6_done_b", 6000);
      check("t6_sram5_chk", sram[5], 8'hAA);

      check("no_back_to_back_mem", b2b, 0);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
